// File: rtl/mem_port_arb.sv
// Arbiter for the shared instruction/data memory port: one transaction outstanding,
// LSU priority with a streak counter that forces an IFU grant after STARVE_LIMIT contested LSU wins.
module mem_port_arb #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ready,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_wen,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wmask,
  output logic                  ls_ready,
  output logic                  ls_rvalid,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  mem_req,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int            SW     = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT  = SW'(STARVE_LIMIT);
  localparam logic          OWN_IF = 1'b0;
  localparam logic          OWN_LS = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_nxt;
  logic          owner;
  logic          grant_if;
  logic          grant_ls;

  // Arbitration in IDLE and the transaction sequencing that follows it
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_ls  = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req && !(if_req && (streak == LIMIT))) begin
          grant_ls  = 1'b1;
          state_nxt = REQ;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) state_nxt = WAIT;
        else         state_nxt = REQ;
      end
      WAIT: begin
        if (mem_rvalid) state_nxt = IDLE;
        else            state_nxt = WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only contested LSU wins count toward starving the IFU
  always_comb begin
    streak_nxt = streak;
    if (grant_if) begin
      streak_nxt = '0;
    end else if (grant_ls && if_req && (streak != LIMIT)) begin
      streak_nxt = streak + 1'b1;
    end else begin
      streak_nxt = streak;
    end
  end

  // State, streak and owner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      streak <= '0;
      owner  <= OWN_IF;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
      if (grant_ls)      owner <= OWN_LS;
      else if (grant_if) owner <= OWN_IF;
      else               owner <= owner;
    end
  end

  // Memory payload latched on accept and held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (grant_ls) begin
      mem_wen   <= ls_wen;
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
      mem_wmask <= ls_wmask;
    end else if (grant_if) begin
      mem_wen   <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      mem_wen   <= mem_wen;
      mem_addr  <= mem_addr;
      mem_wdata <= mem_wdata;
      mem_wmask <= mem_wmask;
    end
  end

  assign if_ready  = grant_if;
  assign ls_ready  = grant_ls;
  assign mem_req   = (state == REQ);
  assign busy      = (state != IDLE);
  // Responses outside WAIT are stray and must not reach either requester
  assign if_rvalid = (state == WAIT) && mem_rvalid && (owner == OWN_IF);
  assign ls_rvalid = (state == WAIT) && mem_rvalid && (owner == OWN_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: vector table plus hand sequences for contention,
// stray responses and reset mid-transaction; responses checked against a scoreboard queue.
module tb_mem_port_arb;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        ls_req;
  logic        ls_wen;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_ready;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        mem_req;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        owner_ls;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    logic        use_ls;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    int          gnt_dly;
    logic        exp_wen;
    logic [7:0]  exp_wmask;
  } vec_t;

  vec_t vecs[6];

  mem_port_arb #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (if_rvalid === 1'b1 || ls_rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, if_rvalid, ls_rvalid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_ls_rvalid", ls_rvalid, mon_e.owner_ls);
        chk("rsp_if_rvalid", if_rvalid, !mon_e.owner_ls);
        chk("rsp_rdata", mon_e.owner_ls ? ls_rdata : if_rdata, mon_e.data);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   mem_req,   64'd0);
    chk({tag, "_mem_wen"},   mem_wen,   64'd0);
    chk({tag, "_mem_addr"},  mem_addr,  64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_mem_wmask"}, mem_wmask, 64'd0);
    chk({tag, "_busy"},      busy,      64'd0);
    chk({tag, "_if_ready"},  if_ready,  64'd0);
    chk({tag, "_ls_ready"},  ls_ready,  64'd0);
    chk({tag, "_if_rvalid"}, if_rvalid, 64'd0);
    chk({tag, "_ls_rvalid"}, ls_rvalid, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  // Entered and left one time unit after a rising edge with the arbiter idle
  task automatic run_txn(input vec_t v, input string tag);
    if (v.use_ls) begin
      ls_req = 1'b1; ls_wen = v.wen; ls_addr = v.addr; ls_wdata = v.wdata; ls_wmask = v.wmask;
      if_addr = 64'hABCD_0000;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      ls_wen = 1'b1; ls_addr = ~v.addr; ls_wdata = 64'hA5A5_A5A5_A5A5_A5A5; ls_wmask = 8'hFF;
    end
    @(negedge clk);
    chk({tag, "_if_ready"}, if_ready, !v.use_ls);
    chk({tag, "_ls_ready"}, ls_ready, v.use_ls);
    chk({tag, "_busy_idle"}, busy, 64'd0);
    sb.push_back('{owner_ls: v.use_ls, data: v.rdata});
    @(posedge clk); #1;
    if_req = 1'b0; ls_req = 1'b0;
    for (int i = 0; i <= v.gnt_dly; i++) begin
      mem_gnt = (i == v.gnt_dly);
      @(negedge clk);
      chk({tag, "_mem_req"},   mem_req,   64'd1);
      chk({tag, "_mem_addr"},  mem_addr,  v.addr);
      chk({tag, "_mem_wen"},   mem_wen,   v.exp_wen);
      chk({tag, "_mem_wmask"}, mem_wmask, v.exp_wmask);
      if (v.use_ls) chk({tag, "_mem_wdata"}, mem_wdata, v.wdata);
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = v.rdata;
    @(negedge clk);
    chk({tag, "_busy_wait"}, busy, 64'd1);
    chk({tag, "_mem_req_wait"}, mem_req, 64'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 64'hDEAD_0000_DEAD_0000;
    @(negedge clk);
    chk({tag, "_busy_done"}, busy, 64'd0);
    chk({tag, "_sb_drain"}, sb.size(), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int   mstreak;
    logic exp_ls;
    vec_t rv;

    vecs[0] = '{1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'h0000_0013, 0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 64'd0, 3, 1'b1, 8'h0F};
    vecs[2] = '{1'b1, 1'b0, 64'h8000_2008, 64'h0, 8'hFF, 64'h1122_3344_5566_7788, 1, 1'b0, 8'hFF};
    vecs[3] = '{1'b0, 1'b0, 64'h8000_0004, 64'd0, 8'h00, 64'hCAFE_F00D_0000_0001, 2, 1'b0, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 64'd0, 0, 1'b1, 8'h80};
    vecs[5] = '{1'b0, 1'b0, 64'h0, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 8'h00};

    rst_n = 1'b0; if_req = 1'b0; if_addr = 64'd0; ls_req = 1'b0; ls_wen = 1'b0;
    ls_addr = 64'd0; ls_wdata = 64'd0; ls_wmask = 8'h00;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    #12;
    chk_all_zero("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_streak", dut.streak, 64'd0);
    chk("rst_owner", dut.owner, 64'd0);
    chk("rst_busy_after", busy, 64'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) run_txn(vecs[k], $sformatf("vec%0d", k));

    // Contention: both held, expect L,L,L,L,I,L,L,L,L,I
    do_reset();
    if_req = 1'b1; ls_req = 1'b1; ls_wen = 1'b0; ls_wmask = 8'hFF; ls_wdata = 64'd0;
    ls_addr = 64'h9000_0000; if_addr = 64'h8000_0100;
    mstreak = 0;
    for (int g = 0; g < 10; g++) begin
      exp_ls = (mstreak != 4);
      @(negedge clk);
      chk($sformatf("cont%0d_ls_ready", g), ls_ready, exp_ls);
      chk($sformatf("cont%0d_if_ready", g), if_ready, !exp_ls);
      sb.push_back('{owner_ls: exp_ls, data: 64'h100 + 64'(g)});
      mstreak = exp_ls ? ((mstreak == 4) ? 4 : mstreak + 1) : 0;
      @(posedge clk); #1 mem_gnt = 1'b1;
      @(negedge clk);
      chk($sformatf("cont%0d_addr", g), mem_addr, exp_ls ? ls_addr : if_addr);
      @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h100 + 64'(g);
      @(posedge clk); #1 mem_rvalid = 1'b0;
      chk($sformatf("cont%0d_streak", g), dut.streak, 64'(mstreak));
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("cont_sb_drain", sb.size(), 64'd0);

    // Stray rvalid/gnt in IDLE, early rvalid in REQ
    @(posedge clk); #1 mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    @(negedge clk);
    chk("stray_idle_busy", busy, 64'd0);
    chk("stray_idle_ls_rvalid", ls_rvalid, 64'd0);
    chk("stray_idle_if_rvalid", if_rvalid, 64'd0);
    @(posedge clk); #1 mem_rvalid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    chk("stray_gnt_busy", busy, 64'd0);
    chk("stray_gnt_mem_req", mem_req, 64'd0);
    @(posedge clk); #1 mem_gnt = 1'b0; ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 64'h8000_3000;
    @(negedge clk);
    chk("early_ls_ready", ls_ready, 64'd1);
    sb.push_back('{owner_ls: 1'b1, data: 64'h5555});
    @(posedge clk); #1 ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    @(negedge clk);
    chk("early_req_ls_rvalid", ls_rvalid, 64'd0);
    chk("early_req_mem_req", mem_req, 64'd1);
    @(posedge clk); #1 mem_rvalid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    chk("early_still_req", mem_req, 64'd1);
    @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h5555;
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    chk("early_busy_done", busy, 64'd0);
    chk("early_sb_drain", sb.size(), 64'd0);

    // Reset while waiting for a store ack
    @(posedge clk); #1 ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_4000;
    ls_wdata = 64'h1234_5678; ls_wmask = 8'h33;
    @(negedge clk);
    chk("rstw_ls_ready", ls_ready, 64'd1);
    sb.push_back('{owner_ls: 1'b1, data: 64'd0});
    @(posedge clk); #1 ls_req = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1 mem_gnt = 1'b0;
    @(negedge clk);
    chk("rstw_busy_wait", busy, 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk_all_zero("rstw");
    @(posedge clk); #1 rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    @(negedge clk);
    chk("rstw_stale_busy", busy, 64'd0);
    chk("rstw_stale_ls_rvalid", ls_rvalid, 64'd0);
    chk("rstw_stale_if_rvalid", if_rvalid, 64'd0);
    @(posedge clk); #1 mem_rvalid = 1'b0;
    rv = '{1'b1, 1'b0, 64'h8000_5000, 64'd0, 8'hFF, 64'h0BAD_C0DE, 0, 1'b0, 8'hFF};
    run_txn(rv, "post_rst");

    chk("final_sb_empty", sb.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Two-requester arbiter and sequencer for the core's single data/instruction memory port. Takes fetch requests from the IFU and load/store requests from the LSU, grants one transaction at a time to the shared memory port, and routes the response back to the owner. LSU has priority, with a starvation limit that forces an IFU grant after a run of LSU grants. Sits between IFU/LSU and the memory interface; its response pulses drive the `inst_update`/`mem_finish` style completion signals of the pipeline control.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 64, data width; `wmask` is `DATA_W/8` bits
- `STARVE_LIMIT`, 4, consecutive contested LSU grants before IFU is forced; must be ≥1
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `if_req`  in  1  IFU fetch request; held with `if_addr` stable until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_ready`  out  1  request accepted this cycle
- `if_rvalid`  out  1  one-cycle fetch response pulse
- `if_rdata`  out  DATA_W  fetch data, valid with `if_rvalid`
- `ls_req`  in  1  LSU request; held with its payload stable until `ls_ready`
- `ls_wen`  in  1  1 = store, 0 = load
- `ls_addr`  in  ADDR_W  access address
- `ls_wdata`  in  DATA_W  store data
- `ls_wmask`  in  DATA_W/8  store byte mask
- `ls_ready`  out  1  request accepted this cycle
- `ls_rvalid`  out  1  one-cycle response pulse, for loads and for store acks
- `ls_rdata`  out  DATA_W  load data, valid with `ls_rvalid` on loads
- `mem_req`  out  1  memory request; held until `mem_gnt`
- `mem_wen`, `mem_addr`, `mem_wdata`, `mem_wmask`  out  1/ADDR_W/DATA_W/DATA_W/8  latched payload
- `mem_gnt`  in  1  memory accepted the request
- `mem_rvalid`  in  1  memory response or write ack; arrives ≥1 cycle after `mem_gnt`
- `mem_rdata`  in  DATA_W  response data
- `busy`  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: no transaction. Exits to REQ when any request is present.
  - REQ: `mem_req`=1. Exits to WAIT on `mem_gnt`.
  - WAIT: waiting for the response. Exits to IDLE on `mem_rvalid`.
- Arbitration in IDLE:
  - Only `ls_req` present: LSU wins. Only `if_req` present: IFU wins.
  - Both present: LSU wins unless `streak == STARVE_LIMIT`, in which case IFU wins.
- Acceptance:
  - On a win, the winner's `*_ready` is 1 (combinational, IDLE only).
  - The payload is latched into the `mem_*` registers, and `owner` is latched.
  - For IFU wins, `mem_wen`=0 and `mem_wmask`=0.
- Streak counter (width `$clog2(STARVE_LIMIT+1)`):
  - +1 on an LSU grant while `if_req`=1, saturating at `STARVE_LIMIT`.
  - Cleared on any IFU grant.
  - Unchanged on an uncontested LSU grant.
- `mem_*` payload registers hold their value from the accept cycle until the next accept.
- Response routing (combinational in WAIT):
  - `if_rvalid = mem_rvalid & owner==IF`; `ls_rvalid = mem_rvalid & owner==LS`.
  - `*_rdata = mem_rdata` (pass-through).
- `mem_rvalid` outside WAIT is ignored: no pulse and no state change.
- At most one outstanding transaction. The other requester's `*_ready` stays 0 until the arbiter returns to IDLE.

## Timing
- Reset values:
  - state IDLE, streak 0, owner IF.
  - All `mem_*` outputs 0, `busy` 0.
  - `if_ready`, `ls_ready`, `if_rvalid`, `ls_rvalid` 0.
- Reset mid-transaction: the transaction is abandoned with no response pulse. A stale `mem_rvalid` after reset is ignored.
- Minimum sequence, with the request present at cycle 0 and `mem_gnt` immediate:
  - cycle 0: `ready` (accept).
  - cycle 1: `mem_req`, `mem_gnt` (REQ).
  - cycle 2: earliest `mem_rvalid` → `*_rvalid` (WAIT).
  - cycle 3: IDLE, next accept possible.
- Throughput is one transaction per 3 cycles at best.
- A request raised in the same cycle the arbiter enters IDLE is arbitrated that cycle.
- `mem_gnt` outside REQ has no effect.

## Test plan
- Single fetch: `if_req`, addr 0x8000_0000; memory grants at cycle 1 and responds at cycle 2 with 0x00000013 → `if_ready` at 0, `mem_addr`=0x8000_0000, `mem_wen`=0, `if_rvalid` at 2, back to IDLE at 3.
- Store: `ls_wen`=1, addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0x0F; `mem_gnt` delayed 3 cycles → `mem_req` held for 4 cycles with a stable payload, then `ls_rvalid` on the ack and `if_rvalid`=0.
- Contention: `if_req` and `ls_req` held continuously, STARVE_LIMIT=4 → grant order L,L,L,L,I,L,L,L,L,I; streak reads 0 after each IFU grant.
- Stray and early responses: `mem_rvalid` pulsed in IDLE and in REQ → no `*_rvalid`, no state change; the later real response is delivered once.
- Reset in WAIT: assert `rst_n`=0 mid-wait, then release and pulse `mem_rvalid` → no response pulse; all outputs 0; next `ls_req` accepted normally.
